// File: rtl/rs_control_unit.sv
// rs_control_unit
//   Hardwired Moore sequencer for the 8-bit accumulator CPU. It walks
//   fetch / decode / execute, drives every datapath register load, bus
//   source enable and memory strobe, supplies the ALU select lines, and
//   owns the architectural Z flag.
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   DR_IN[7:0]         DR contents, decoded as the opcode in FETCH3
//   Z_IN               accumulator zero-detect of the current ALU result
//   *_LOAD / *_INC     register controls; AR_SRC selects AR <- PC (0) or {DR,TR} (1)
//   *_BUS              bus source enables (at most one high per state)
//   MEM_READ/MEM_WRITE memory strobes at address AR
//   ALUS1..ALUS7       ALU select lines
//   Z_FLAG             architectural zero flag
//   STATE[5:0]         current state code (RESET0 = 0, FETCH1 = 1, ...)
module rs_control_unit (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] DR_IN,
    input  logic       Z_IN,
    output logic       AR_LOAD,
    output logic       AR_INC,
    output logic       PC_LOAD,
    output logic       PC_INC,
    output logic       DR_LOAD,
    output logic       TR_LOAD,
    output logic       IR_LOAD,
    output logic       R_LOAD,
    output logic       AC_LOAD,
    output logic       AR_SRC,
    output logic       PC_BUS,
    output logic       DR_BUS,
    output logic       TR_BUS,
    output logic       R_BUS,
    output logic       AC_BUS,
    output logic       MEM_READ,
    output logic       MEM_WRITE,
    output logic       ALUS1,
    output logic       ALUS2,
    output logic       ALUS3,
    output logic       ALUS4,
    output logic       ALUS5,
    output logic       ALUS6,
    output logic       ALUS7,
    output logic       Z_FLAG,
    output logic [5:0] STATE
);

    typedef enum logic [5:0] {
        RESET0, FETCH1, FETCH2, FETCH3, NOP1,
        LDAC1, LDAC2, LDAC3, LDAC4, LDAC5,
        STAC1, STAC2, STAC3, STAC4, STAC5,
        MVAC1, MOVR1, JUMP1, JUMP2, JUMP3,
        JMPZY1, JMPZY2, JMPZY3, JMPZN1, JMPZN2,
        JPNZY1, JPNZY2, JPNZY3, JPNZN1, JPNZN2,
        ADD1, SUB1, INAC1, CLAC1, AND1, OR1, XOR1, NOT1
    } state_t;

    state_t     state, state_nxt;
    logic       z_flag;
    logic [6:0] alus;   // {ALUS1..ALUS4, ALUS5, ALUS6, ALUS7}

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= RESET0;
        else        state <= state_nxt;
    end

    // Z tracks the accumulator: it only moves on edges that load AC.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)       z_flag <= 1'b0;
        else if (AC_LOAD) z_flag <= Z_IN;
    end

    always_comb begin
        state_nxt = FETCH1;   // every final execute state returns to fetch
        case (state)
            FETCH1: state_nxt = FETCH2;
            FETCH2: state_nxt = FETCH3;
            FETCH3: begin
                // Bytes with a nonzero high nibble fall through as NOP.
                if (DR_IN[7:4] != 4'h0) state_nxt = NOP1;
                else begin
                    case (DR_IN[3:0])
                        4'h0: state_nxt = NOP1;
                        4'h1: state_nxt = LDAC1;
                        4'h2: state_nxt = STAC1;
                        4'h3: state_nxt = MVAC1;
                        4'h4: state_nxt = MOVR1;
                        4'h5: state_nxt = JUMP1;
                        4'h6: state_nxt = z_flag ? JMPZY1 : JMPZN1;
                        4'h7: state_nxt = z_flag ? JPNZN1 : JPNZY1;
                        4'h8: state_nxt = ADD1;
                        4'h9: state_nxt = SUB1;
                        4'hA: state_nxt = INAC1;
                        4'hB: state_nxt = CLAC1;
                        4'hC: state_nxt = AND1;
                        4'hD: state_nxt = OR1;
                        4'hE: state_nxt = XOR1;
                        default: state_nxt = NOT1;
                    endcase
                end
            end
            LDAC1:  state_nxt = LDAC2;
            LDAC2:  state_nxt = LDAC3;
            LDAC3:  state_nxt = LDAC4;
            LDAC4:  state_nxt = LDAC5;
            STAC1:  state_nxt = STAC2;
            STAC2:  state_nxt = STAC3;
            STAC3:  state_nxt = STAC4;
            STAC4:  state_nxt = STAC5;
            JUMP1:  state_nxt = JUMP2;
            JUMP2:  state_nxt = JUMP3;
            JMPZY1: state_nxt = JMPZY2;
            JMPZY2: state_nxt = JMPZY3;
            JMPZN1: state_nxt = JMPZN2;
            JPNZY1: state_nxt = JPNZY2;
            JPNZY2: state_nxt = JPNZY3;
            JPNZN1: state_nxt = JPNZN2;
            default: state_nxt = FETCH1;
        endcase
    end

    always_comb begin
        AR_LOAD = 1'b0; AR_INC = 1'b0; PC_LOAD = 1'b0; PC_INC = 1'b0;
        DR_LOAD = 1'b0; TR_LOAD = 1'b0; IR_LOAD = 1'b0; R_LOAD = 1'b0;
        AC_LOAD = 1'b0; AR_SRC = 1'b0;
        PC_BUS = 1'b0; DR_BUS = 1'b0; TR_BUS = 1'b0; R_BUS = 1'b0; AC_BUS = 1'b0;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        alus = 7'b0000_00_0;
        case (state)
            FETCH1: AR_LOAD = 1'b1;
            FETCH2: begin MEM_READ = 1'b1; DR_LOAD = 1'b1; PC_INC = 1'b1; end
            FETCH3: begin IR_LOAD = 1'b1; AR_LOAD = 1'b1; end
            LDAC1, STAC1: begin
                MEM_READ = 1'b1; DR_LOAD = 1'b1; PC_INC = 1'b1; AR_INC = 1'b1;
            end
            LDAC2, STAC2: begin
                TR_LOAD = 1'b1; MEM_READ = 1'b1; DR_LOAD = 1'b1; PC_INC = 1'b1;
            end
            LDAC3, STAC3: begin AR_LOAD = 1'b1; AR_SRC = 1'b1; end
            LDAC4:  begin MEM_READ = 1'b1; DR_LOAD = 1'b1; end
            LDAC5:  begin DR_BUS = 1'b1; AC_LOAD = 1'b1; alus = 7'b0100_00_0; end
            STAC4:  begin AC_BUS = 1'b1; DR_LOAD = 1'b1; end
            STAC5:  begin DR_BUS = 1'b1; MEM_WRITE = 1'b1; end
            MVAC1:  begin AC_BUS = 1'b1; R_LOAD = 1'b1; end
            MOVR1:  begin R_BUS = 1'b1; AC_LOAD = 1'b1; alus = 7'b0100_00_0; end
            JUMP1, JMPZY1, JPNZY1: begin MEM_READ = 1'b1; DR_LOAD = 1'b1; AR_INC = 1'b1; end
            JUMP2, JMPZY2, JPNZY2: begin TR_LOAD = 1'b1; MEM_READ = 1'b1; DR_LOAD = 1'b1; end
            JUMP3, JMPZY3, JPNZY3: PC_LOAD = 1'b1;
            // Not-taken branch skips the two address bytes.
            JMPZN1, JMPZN2, JPNZN1, JPNZN2: PC_INC = 1'b1;
            ADD1:   begin R_BUS = 1'b1; AC_LOAD = 1'b1; alus = 7'b1100_00_0; end
            SUB1:   begin R_BUS = 1'b1; AC_LOAD = 1'b1; alus = 7'b1011_00_0; end
            INAC1:  begin AC_LOAD = 1'b1; alus = 7'b1001_00_0; end
            CLAC1:  begin AC_LOAD = 1'b1; alus = 7'b0000_00_0; end
            AND1:   begin R_BUS = 1'b1; AC_LOAD = 1'b1; alus = 7'b0000_00_1; end
            OR1:    begin R_BUS = 1'b1; AC_LOAD = 1'b1; alus = 7'b0000_01_1; end
            XOR1:   begin R_BUS = 1'b1; AC_LOAD = 1'b1; alus = 7'b0000_10_1; end
            NOT1:   begin AC_LOAD = 1'b1; alus = 7'b0000_11_1; end
            default: ;
        endcase
    end

    assign {ALUS1, ALUS2, ALUS3, ALUS4, ALUS5, ALUS6, ALUS7} = alus;
    assign Z_FLAG = z_flag;
    assign STATE  = state;

endmodule

// File: tb/tb_rs_control_unit.sv
// Bench for rs_control_unit: a per-instruction model expands each opcode
// into the cycle-by-cycle list of expected control words and Z values;
// one negedge process compares the DUT against that list.
module tb_rs_control_unit;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] DR_IN = 8'h00;
    logic       Z_IN = 1'b0;
    logic AR_LOAD, AR_INC, PC_LOAD, PC_INC, DR_LOAD, TR_LOAD, IR_LOAD, R_LOAD, AC_LOAD, AR_SRC;
    logic PC_BUS, DR_BUS, TR_BUS, R_BUS, AC_BUS, MEM_READ, MEM_WRITE;
    logic ALUS1, ALUS2, ALUS3, ALUS4, ALUS5, ALUS6, ALUS7, Z_FLAG;
    logic [5:0] STATE;

    rs_control_unit dut (
        .CLK(CLK), .RST_N(RST_N), .DR_IN(DR_IN), .Z_IN(Z_IN),
        .AR_LOAD(AR_LOAD), .AR_INC(AR_INC), .PC_LOAD(PC_LOAD), .PC_INC(PC_INC),
        .DR_LOAD(DR_LOAD), .TR_LOAD(TR_LOAD), .IR_LOAD(IR_LOAD), .R_LOAD(R_LOAD),
        .AC_LOAD(AC_LOAD), .AR_SRC(AR_SRC),
        .PC_BUS(PC_BUS), .DR_BUS(DR_BUS), .TR_BUS(TR_BUS), .R_BUS(R_BUS), .AC_BUS(AC_BUS),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .ALUS1(ALUS1), .ALUS2(ALUS2), .ALUS3(ALUS3), .ALUS4(ALUS4),
        .ALUS5(ALUS5), .ALUS6(ALUS6), .ALUS7(ALUS7),
        .Z_FLAG(Z_FLAG), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    logic [23:0] dut_ctl;
    assign dut_ctl = {AR_LOAD, AR_INC, PC_LOAD, PC_INC, DR_LOAD, TR_LOAD, IR_LOAD, R_LOAD,
                      AC_LOAD, AR_SRC, PC_BUS, DR_BUS, TR_BUS, R_BUS, AC_BUS,
                      MEM_READ, MEM_WRITE, ALUS1, ALUS2, ALUS3, ALUS4, ALUS5, ALUS6, ALUS7};

    localparam logic [23:0] ARL = 24'h1 << 23, ARI = 24'h1 << 22, PCL = 24'h1 << 21,
                            PCI = 24'h1 << 20, DRL = 24'h1 << 19, TRL = 24'h1 << 18,
                            IRL = 24'h1 << 17, RL  = 24'h1 << 16, ACL = 24'h1 << 15,
                            ARS = 24'h1 << 14, DRB = 24'h1 << 12, RB  = 24'h1 << 10,
                            ACB = 24'h1 << 9,  MRD = 24'h1 << 8,  MWR = 24'h1 << 7;
    // ALU codes in {ALUS1..4, ALUS5, ALUS6, ALUS7} order.
    localparam logic [23:0] A_PASS = 24'b0100_00_0, A_ADD = 24'b1100_00_0,
                            A_SUB  = 24'b1011_00_0, A_INC = 24'b1001_00_0,
                            A_CLR  = 24'b0000_00_0, A_AND = 24'b0000_00_1,
                            A_OR   = 24'b0000_01_1, A_XOR = 24'b0000_10_1,
                            A_NOT  = 24'b0000_11_1;

    logic [23:0] exp_w[$];
    logic        exp_z[$];
    logic        mz = 1'b0;     // model Z flag
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Expand one instruction into per-cycle expectations; stop_after trims it.
    function automatic int build(input logic [7:0] op, input logic zin, input int stop_after);
        logic [23:0] q[$];
        logic [23:0] jmp[$];
        int          n;
        q = '{ARL, MRD | DRL | PCI, IRL | ARL};
        jmp = '{MRD | DRL | ARI, TRL | MRD | DRL, PCL};
        if (op[7:4] != 4'h0) q.push_back(24'h0);
        else case (op[3:0])
            4'h0: q.push_back(24'h0);
            4'h1: q = {q, MRD | DRL | PCI | ARI, TRL | MRD | DRL | PCI, ARL | ARS,
                       MRD | DRL, DRB | ACL | A_PASS};
            4'h2: q = {q, MRD | DRL | PCI | ARI, TRL | MRD | DRL | PCI, ARL | ARS,
                       ACB | DRL, DRB | MWR};
            4'h3: q.push_back(ACB | RL);
            4'h4: q.push_back(RB | ACL | A_PASS);
            4'h5: q = {q, jmp};
            4'h6: if (mz)  q = {q, jmp}; else q = {q, PCI, PCI};
            4'h7: if (!mz) q = {q, jmp}; else q = {q, PCI, PCI};
            4'h8: q.push_back(RB | ACL | A_ADD);
            4'h9: q.push_back(RB | ACL | A_SUB);
            4'hA: q.push_back(ACL | A_INC);
            4'hB: q.push_back(ACL | A_CLR);
            4'hC: q.push_back(RB | ACL | A_AND);
            4'hD: q.push_back(RB | ACL | A_OR);
            4'hE: q.push_back(RB | ACL | A_XOR);
            default: q.push_back(ACL | A_NOT);
        endcase
        n = (stop_after < q.size()) ? stop_after : q.size();
        for (int i = 0; i < n; i++) begin
            exp_w.push_back(q[i]);
            exp_z.push_back(mz);
            if (q[i][15]) mz = zin;
        end
        return q.size();
    endfunction

    // Called at posedge+1 with the DUT in FETCH1; returns at posedge+1 of the next FETCH1.
    task automatic run(input logic [7:0] op, input logic zin, input int stop_after, output int len);
        int c;
        DR_IN = op;
        Z_IN  = zin;
        len = build(op, zin, stop_after);
        c = 0;
        while (exp_w.size() > 0 && c < 40) begin
            @(posedge CLK);
            c++;
        end
        #1;
        if (exp_w.size() > 0) begin
            chk("drain_timeout", exp_w.size(), 0);
            exp_w.delete();
            exp_z.delete();
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            chk("bus_onehot0", ($countones({PC_BUS, DR_BUS, TR_BUS, R_BUS, AC_BUS}) <= 1), 1);
            chk("mem_rw_excl", (MEM_READ && MEM_WRITE), 0);
            if (exp_w.size() > 0) begin
                chk("ctl", dut_ctl, exp_w.pop_front());
                chk("zflag", Z_FLAG, exp_z.pop_front());
            end
        end
    end

    initial begin
        int len;
        repeat (2) @(negedge CLK);
        chk("rst_ctl", dut_ctl, 0);
        chk("rst_state", STATE, 0);
        chk("rst_z", Z_FLAG, 0);
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("fetch1_arload", {AR_LOAD, AR_SRC}, 2'b10);

        run(8'h00, 1'b0, 99, len); chk("len_nop", len, 4);
        run(8'h01, 1'b0, 99, len); chk("len_ldac", len, 8);
        run(8'h08, 1'b1, 99, len); chk("len_add", len, 4);
        chk("z_after_add", Z_FLAG, 1);
        run(8'h06, 1'b0, 99, len); chk("len_jmpz_taken", len, 6);
        run(8'h09, 1'b0, 99, len);
        chk("z_after_sub", Z_FLAG, 0);
        run(8'h06, 1'b1, 99, len); chk("len_jmpz_not", len, 5);
        run(8'h07, 1'b0, 99, len); chk("len_jpnz_taken", len, 6);
        run(8'h0A, 1'b1, 99, len);
        run(8'h07, 1'b0, 99, len); chk("len_jpnz_not", len, 5);
        run(8'h2F, 1'b0, 99, len); chk("len_hi_nibble_nop", len, 4);
        run(8'h03, 1'b1, 99, len);
        run(8'h04, 1'b0, 99, len);
        run(8'h0B, 1'b1, 99, len);
        run(8'h0C, 1'b0, 99, len);
        run(8'h0D, 1'b1, 99, len);
        run(8'h0E, 1'b0, 99, len);
        run(8'h0F, 1'b1, 99, len);
        run(8'h05, 1'b0, 99, len); chk("len_jump", len, 6);
        run(8'h02, 1'b0, 99, len); chk("len_stac", len, 8);
        run(8'h08, 1'b1, 99, len);

        // Abort STAC in STAC4: outputs must drop at once and no write may follow.
        run(8'h02, 1'b0, 6, len);
        chk("stac4_entered", {AC_BUS, DR_LOAD, MEM_WRITE}, 3'b110);
        #2 RST_N = 1'b0;
        #1;
        chk("abort_ctl", dut_ctl, 0);
        chk("abort_state", STATE, 0);
        chk("abort_z", Z_FLAG, 0);
        mz = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            chk("abort_no_write", MEM_WRITE, 0);
        end
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("refetch_arload", {AR_LOAD, AR_SRC}, 2'b10);
        run(8'h00, 1'b0, 99, len);
        run(8'h07, 1'b0, 99, len); chk("len_jpnz_after_rst", len, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
